// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_pkg
// Desc    : Shared encodings, FSM state type and byte-mask helper for the
//           memory-stage access unit.
// Rev     : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module : dmem_bank
// Desc   : Single-port synchronous RAM with per-byte write enables and a
//          one-cycle registered read.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_bank #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic [XLEN/8-1:0]        we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [XLEN-1:0]          wdata_i,
    output logic [XLEN-1:0]          rdata_o
);
    localparam int BE_W = XLEN / 8;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int j = 0; j < BE_W; j++) begin
            if (we_i[j]) begin
                mem_q[idx_i][j*8 +: 8] <= wdata_i[j*8 +: 8];
            end
        end
        if (en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// Desc   : Memory stage: sized stores with byte enables, extended loads,
//          write-only MMIO shadow words and a valid/ready write-back port.
// Rev    : 1.0  initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 1024,
    parameter int MMIO_WORDS = 4,
    localparam int BE_W      = XLEN / 8,
    localparam int ADDR_W    = $clog2(DEPTH) + $clog2(BE_W)
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [1:0]                 wb_select,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [XLEN-1:0]            req_wdata,
    input  logic [XLEN-1:0]            alu_res,
    input  logic [XLEN-1:0]            pc_plus_4,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [XLEN-1:0]            resp_data,
    output logic                       resp_err,
    output logic [MMIO_WORDS*XLEN-1:0] mmio_out
);
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [OFF_W-1:0]  ld_off_q, ld_off_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_uns_q, ld_uns_d;
    logic [XLEN-1:0]   mmio_q [MMIO_WORDS];

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [2:0]        w_align_m;
    logic              w_err, w_accept, w_store, w_load;
    logic [BE_W-1:0]   w_be;
    logic [XLEN-1:0]   w_wdata_rep, w_rdata, w_shift, w_ext;
    int                w_msb;

    assign w_off     = req_addr[OFF_W-1:0];
    assign w_idx     = req_addr[ADDR_W-1:OFF_W];
    assign w_align_m = 3'((4'd1 << req_size) - 4'd1);
    assign w_err     = (|(req_addr[2:0] & w_align_m)) || (req_size == SZ_D && XLEN == 32);
    assign w_accept  = req_valid && (state_q == IDLE);
    assign w_store   = req_write && !w_err;
    assign w_load    = !req_write && (wb_select == WB_MEM) && !w_err;
    assign w_be      = (w_accept && w_store) ? (BE_W'(size_mask(req_size)) << w_off) : '0;

    // Lane j takes byte (j mod access-bytes) of the right-aligned store data.
    always_comb begin
        w_wdata_rep = '0;
        for (int j = 0; j < BE_W; j++) begin
            w_wdata_rep[j*8 +: 8] = req_wdata[(j & ((1 << req_size) - 1))*8 +: 8];
        end
    end

    dmem_bank #(.XLEN(XLEN), .DEPTH(DEPTH)) u_dmem (
        .clk_i   (sys_clk),
        .en_i    (w_accept && w_load),
        .we_i    (w_be),
        .idx_i   (w_idx),
        .wdata_i (w_wdata_rep),
        .rdata_o (w_rdata)
    );

    always_comb begin
        w_shift = w_rdata >> {ld_off_q, 3'b000};
        case (ld_size_q)
            SZ_B:    w_msb = 7;
            SZ_H:    w_msb = 15;
            SZ_W:    w_msb = 31;
            default: w_msb = XLEN - 1;
        endcase
        w_ext = w_shift;
        for (int i = 0; i < XLEN; i++) begin
            if (i > w_msb) w_ext[i] = ld_uns_q ? 1'b0 : w_shift[w_msb];
        end
    end

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        ld_off_d    = ld_off_q;
        ld_size_d   = ld_size_q;
        ld_uns_d    = ld_uns_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ld_off_d  = w_off;
                    ld_size_d = req_size;
                    ld_uns_d  = req_unsigned;
                    if (w_err) begin
                        state_d     = RESP;
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                    end else if (w_load) begin
                        state_d    = RD_WAIT;
                        resp_err_d = 1'b0;
                    end else begin
                        state_d     = RESP;
                        resp_err_d  = 1'b0;
                        resp_data_d = (wb_select == WB_PC) ? pc_plus_4 : alu_res;
                    end
                end
            end
            RD_WAIT: begin
                state_d     = RESP;
                resp_data_d = w_ext;
            end
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            ld_off_q    <= '0;
            ld_size_q   <= SZ_B;
            ld_uns_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            ld_off_q    <= ld_off_d;
            ld_size_q   <= ld_size_d;
            ld_uns_q    <= ld_uns_d;
        end
    end

    // Shadow words mirror stores to the top MMIO_WORDS RAM words.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int k = 0; k < MMIO_WORDS; k++) mmio_q[k] <= '0;
        end else begin
            for (int k = 0; k < MMIO_WORDS; k++) begin
                if (w_idx == IDX_W'(DEPTH - MMIO_WORDS + k)) begin
                    for (int j = 0; j < BE_W; j++) begin
                        if (w_be[j]) mmio_q[k][j*8 +: 8] <= w_wdata_rep[j*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < MMIO_WORDS; k++) begin : g_mmio_out
        assign mmio_out[k*XLEN +: XLEN] = mmio_q[k];
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_unit
// Desc   : Directed scoreboard bench for mem_access_unit (XLEN=64, DEPTH=1024).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;
    localparam int XLEN = 64;
    localparam int AW   = 13;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic            req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]      req_size, wb_select;
    logic [AW-1:0]   req_addr;
    logic [XLEN-1:0] req_wdata, alu_res, pc_plus_4, resp_data;
    logic            resp_valid, resp_ready, resp_err;
    logic [255:0]    mmio_out;

    logic [64:0]     exp_q [$];
    int              total = 0;
    int              fails = 0;

    mem_access_unit dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .wb_select(wb_select),
        .req_addr(req_addr), .req_wdata(req_wdata), .alu_res(alu_res),
        .pc_plus_4(pc_plus_4), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .mmio_out(mmio_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [1:0] wb, input logic [AW-1:0] addr,
                         input logic [63:0] wd, input logic [63:0] alu, input logic [63:0] pc);
        req_write = wr; req_size = sz; req_unsigned = uns; wb_select = wb;
        req_addr = addr; req_wdata = wd; alu_res = alu; pc_plus_4 = pc;
        req_valid = 1'b1;
    endtask

    // One full transaction: drive, accept, measure latency, compare, consume.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [1:0] wb, input logic [AW-1:0] addr,
                          input logic [63:0] wd, input logic [63:0] alu, input logic [63:0] pc,
                          input logic [63:0] ed, input logic ee, input int lat, input string tag);
        int n;
        logic [64:0] e;
        @(negedge sys_clk);
        drive(wr, sz, uns, wb, addr, wd, alu, pc);
        chk({63'd0, req_ready}, 64'd1, {tag, ".ready"});
        exp_q.push_back({ee, ed});
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 8) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk(64'(n), 64'(lat), {tag, ".latency"});
        e = exp_q.pop_front();
        if (resp_valid) begin
            chk(resp_data, e[63:0], {tag, ".data"});
            chk({63'd0, resp_err}, {63'd0, e[64]}, {tag, ".err"});
        end else begin
            chk({63'd0, resp_valid}, 64'd1, {tag, ".timeout"});
        end
        @(posedge sys_clk); #1;
    endtask

    initial begin
        logic [64:0] e;
        int n;
        sys_rst = 1'b1; resp_ready = 1'b1;
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        req_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk({63'd0, req_ready},  64'd1, "rst.ready");
        chk({63'd0, resp_valid}, 64'd0, "rst.valid");
        chk(resp_data,           64'd0, "rst.data");
        chk({63'd0, resp_err},   64'd0, "rst.err");
        for (int k = 0; k < 4; k++) chk(mmio_out[k*64 +: 64], 64'd0, "rst.mmio");

        // Byte store into shadow word 0, lane 3.
        do_req(1, 2'd0, 0, 2'd0, 13'd8163, 64'hAB, 64'h55, 64'h0, 64'h55, 0, 0, "st_b_mmio");
        chk(mmio_out[63:0],    64'h00000000AB000000, "mmio0");
        chk(mmio_out[127:64],  64'd0, "mmio1");
        do_req(1, 2'd3, 0, 2'd0, 13'd8184, 64'h1122334455667788, 64'h66, 64'h0, 64'h66, 0, 0, "st_d_mmio3");
        chk(mmio_out[255:192], 64'h1122334455667788, "mmio3");
        do_req(0, 2'd0, 1, 2'd1, 13'd8163, 64'h0, 64'h0, 64'h0, 64'hAB, 0, 1, "ld_b_mmio");

        // Half store with wb_select=MEM answers with the ALU value.
        do_req(1, 2'd1, 0, 2'd1, 13'h10, 64'h8001, 64'h77, 64'h0, 64'h77, 0, 0, "st_h");
        do_req(0, 2'd1, 0, 2'd1, 13'h10, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFF8001, 0, 1, "ld_h_s");
        do_req(0, 2'd1, 1, 2'd1, 13'h10, 64'h0, 64'h0, 64'h0, 64'h0000000000008001, 0, 1, "ld_h_u");
        do_req(0, 2'd0, 0, 2'd1, 13'h11, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 1, "ld_b_s");

        // Misaligned accesses take the error route with zero data.
        do_req(1, 2'd2, 0, 2'd0, 13'h4, 64'h11223344, 64'h1, 64'h0, 64'h1, 0, 0, "st_w");
        do_req(1, 2'd2, 0, 2'd0, 13'h6, 64'hDEADBEEF, 64'h2, 64'h0, 64'h0, 1, 0, "st_w_mis");
        do_req(0, 2'd1, 0, 2'd1, 13'h11, 64'h0, 64'h3, 64'h0, 64'h0, 1, 0, "ld_h_mis");
        do_req(0, 2'd2, 1, 2'd1, 13'h4, 64'h0, 64'h0, 64'h0, 64'h11223344, 0, 1, "ld_w_u");
        do_req(0, 2'd2, 0, 2'd1, 13'h4, 64'h0, 64'h0, 64'h0, 64'h11223344, 0, 1, "ld_w_s");
        do_req(1, 2'd3, 0, 2'd0, 13'h18, 64'h0123456789ABCDEF, 64'h4, 64'h0, 64'h4, 0, 0, "st_d");
        do_req(0, 2'd3, 0, 2'd1, 13'h18, 64'h0, 64'h0, 64'h0, 64'h0123456789ABCDEF, 0, 1, "ld_d");

        // Pass-through selections.
        do_req(0, 2'd0, 0, 2'd2, 13'h0, 64'h0, 64'hBEEF, 64'h1004, 64'h1004, 0, 0, "pass_pc");
        do_req(0, 2'd0, 0, 2'd3, 13'h0, 64'h0, 64'hCAFE, 64'h1004, 64'hCAFE, 0, 0, "pass_rsv");

        // Backpressure: response held, new request ignored.
        resp_ready = 1'b0;
        @(negedge sys_clk);
        drive(0, 2'd2, 1, 2'd1, 13'h4, 64'h0, 64'h0, 64'h0);
        exp_q.push_back({1'b0, 64'h11223344});
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 8) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk(64'(n), 64'd1, "bp.latency");
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            drive(0, 2'd0, 0, 2'd0, 13'h0, 64'h0, 64'h999, 64'h0);
            chk({63'd0, resp_valid}, 64'd1, "bp.valid");
            chk(resp_data, e[63:0], "bp.data");
            chk({63'd0, req_ready}, 64'd0, "bp.ready");
        end
        @(negedge sys_clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge sys_clk); #1;
        chk({63'd0, resp_valid}, 64'd0, "bp.drain_valid");
        chk({63'd0, req_ready},  64'd1, "bp.drain_ready");

        // Reset while a load waits on the RAM.
        @(negedge sys_clk);
        drive(0, 2'd2, 1, 2'd1, 13'h4, 64'h0, 64'h0, 64'h0);
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        chk({63'd0, req_ready}, 64'd0, "rdw.busy");
        sys_rst = 1'b1;
        #1;
        chk({63'd0, resp_valid}, 64'd0, "rdw.valid");
        chk({63'd0, req_ready},  64'd1, "rdw.ready");
        chk(mmio_out[63:0],      64'd0, "rdw.mmio0");
        chk(mmio_out[255:192],   64'd0, "rdw.mmio3");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        do_req(0, 2'd2, 1, 2'd1, 13'h4, 64'h0, 64'h0, 64'h0, 64'h11223344, 0, 1, "ld_after_rst");
        do_req(0, 2'd1, 1, 2'd1, 13'h10, 64'h0, 64'h0, 64'h0, 64'h8001, 0, 1, "ld_h_after_rst");

        chk(64'(exp_q.size()), 64'd0, "sb.empty");
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
